// File: rtl/obi_burst_master.sv
// obi_burst_master: burst initiator for the req/gnt/rvalid data port.
// Issues incrementing word requests and streams read responses back.
module obi_burst_master #(
    parameter int ADDR_WIDTH      = 16,
    parameter int LEN_WIDTH       = 8,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]  cmd_len_i,
    input  logic                  cmd_we_i,
    input  logic [3:0]            cmd_be_i,
    input  logic                  wdata_valid_i,
    output logic                  wdata_ready_o,
    input  logic [31:0]           wdata_i,
    output logic                  rdata_valid_o,
    output logic [31:0]           rdata_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  data_req_o,
    output logic [ADDR_WIDTH-1:0] data_addr_o,
    output logic                  data_we_o,
    output logic [3:0]            data_be_o,
    output logic [31:0]           data_wdata_o,
    input  logic                  data_gnt_i,
    input  logic                  data_rvalid_i,
    input  logic [31:0]           data_rdata_i
);
    localparam int RW = LEN_WIDTH + 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_WIDTH-1:0] addr;
    logic [RW-1:0]         remaining;
    logic [RW-1:0]         unbuffered;
    logic                  we;
    logic [3:0]            be;
    logic [CW-1:0]         outstanding;
    logic [31:0]           wbuf;
    logic                  wbuf_full;
    logic                  done;
    logic                  err;
    logic                  rd_valid;
    logic [31:0]           rd_data;
    logic                  finish;

    logic accept;
    logic resp;
    logic stray;
    logic wload;
    logic cmd_fire;

    assign accept   = data_req_o & data_gnt_i;
    assign resp     = data_rvalid_i & (outstanding != '0);
    assign stray    = data_rvalid_i & (outstanding == '0);
    assign wload    = wdata_valid_i & wdata_ready_o;
    assign cmd_fire = cmd_valid_i & cmd_ready_o;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        cmd_ready_o   = 1'b0;
        busy_o        = 1'b1;
        data_req_o    = 1'b0;
        wdata_ready_o = 1'b0;
        finish        = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (cmd_valid_i) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                // Count only falls while a request waits, so req stays up.
                data_req_o = (outstanding < MAX_CNT) & (~we | wbuf_full);
                wdata_ready_o = we & ~wbuf_full & (unbuffered != '0);
                if (data_req_o && data_gnt_i && remaining == RW'(1)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (data_rvalid_i && outstanding == CW'(1)) begin
                    state_next = IDLE;
                    finish     = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr        <= '0;
            remaining   <= '0;
            unbuffered  <= '0;
            we          <= 1'b0;
            be          <= '0;
            outstanding <= '0;
            wbuf        <= '0;
            wbuf_full   <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
        end else begin
            done     <= finish;
            rd_valid <= data_rvalid_i & ~we & (outstanding != '0);
            rd_data  <= data_rdata_i;
            if (stray) begin
                err <= 1'b1;
            end
            if (accept && !resp) begin
                outstanding <= outstanding + CW'(1);
            end else if (!accept && resp) begin
                outstanding <= outstanding - CW'(1);
            end
            if (cmd_fire) begin
                addr       <= cmd_addr_i & ~ADDR_WIDTH'(3);
                remaining  <= {1'b0, cmd_len_i} + RW'(1);
                unbuffered <= {1'b0, cmd_len_i} + RW'(1);
                we         <= cmd_we_i;
                be         <= cmd_be_i;
            end else if (accept) begin
                addr      <= addr + ADDR_WIDTH'(4);
                remaining <= remaining - RW'(1);
            end
            if (wload) begin
                wbuf       <= wdata_i;
                wbuf_full  <= 1'b1;
                unbuffered <= unbuffered - RW'(1);
            end else if (accept) begin
                wbuf_full <= 1'b0;
            end
        end
    end

    assign data_addr_o   = addr;
    assign data_we_o     = we;
    assign data_be_o     = be;
    assign data_wdata_o  = wbuf;
    assign done_o        = done;
    assign err_o         = err;
    assign rdata_valid_o = rd_valid;
    assign rdata_o       = rd_data;
endmodule

// File: tb/tb_obi_burst_master.sv
// tb_obi_burst_master: directed bench with a RAM responder model.
// Responder and write stream change on the falling edge.
module tb_obi_burst_master;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [15:0] cmd_addr_i;
    logic [7:0]  cmd_len_i;
    logic        cmd_we_i;
    logic [3:0]  cmd_be_i;
    logic        wdata_valid_i;
    logic        wdata_ready_o;
    logic [31:0] wdata_i;
    logic        rdata_valid_o;
    logic [31:0] rdata_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic        data_req_o;
    logic [15:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;

    obi_burst_master #(
        .ADDR_WIDTH(16),
        .LEN_WIDTH(8),
        .MAX_OUTSTANDING(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_addr_i(cmd_addr_i),
        .cmd_len_i(cmd_len_i),
        .cmd_we_i(cmd_we_i),
        .cmd_be_i(cmd_be_i),
        .wdata_valid_i(wdata_valid_i),
        .wdata_ready_o(wdata_ready_o),
        .wdata_i(wdata_i),
        .rdata_valid_o(rdata_valid_o),
        .rdata_o(rdata_o),
        .busy_o(busy_o),
        .done_o(done_o),
        .err_o(err_o),
        .data_req_o(data_req_o),
        .data_addr_o(data_addr_o),
        .data_we_o(data_we_o),
        .data_be_o(data_be_o),
        .data_wdata_o(data_wdata_o),
        .data_gnt_i(data_gnt_i),
        .data_rvalid_i(data_rvalid_i),
        .data_rdata_i(data_rdata_i)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hFFFF_FFFF;
    endfunction

    logic [31:0] mem [0:16383];
    bit          lv [0:8];
    logic [31:0] ld [0:8];
    logic [31:0] acc_addr [$];
    logic [31:0] acc_be [$];
    logic [31:0] rd_q [$];
    logic [31:0] wq [$];

    int lat = 1;
    int stall_beat = -1;
    int stall_left = 0;
    bit spur = 1'b0;
    int wgap = 0;
    int wgap_cnt = 0;
    int cyc = 0;
    int acc_cnt, wsent, out_m, max_out, acc_before_rv, both_cnt;
    int stab_err, empty_err, held, last_rv_cyc, done_cyc;
    bit seen_rv, pend;
    logic [15:0] p_addr;
    logic [31:0] p_wd;
    logic [3:0]  p_be;
    logic        p_we;
    bit r_acc, r_rv;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) lv[i] = 1'b0;
            data_rvalid_i = 1'b0;
            data_gnt_i = 1'b0;
            wdata_valid_i = 1'b0;
            out_m = 0;
            pend = 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                lv[i] = lv[i+1];
                ld[i] = ld[i+1];
            end
            lv[8] = 1'b0;
            r_rv = lv[0] | spur;
            spur = 1'b0;
            data_rvalid_i = r_rv;
            data_rdata_i = lv[0] ? ld[0] : 32'hBAD0_BAD0;
            if (rdata_valid_o) rd_q.push_back(rdata_o);

            wdata_valid_i = (wq.size() > 0) && (wgap_cnt == 0);
            if (wdata_valid_i) wdata_i = wq[0];
            if (data_req_o && data_we_o && acc_cnt >= wsent) empty_err++;
            if (wdata_valid_i && wdata_ready_o) begin
                wsent++;
                void'(wq.pop_front());
                wgap_cnt = wgap;
            end else if (wgap_cnt > 0) begin
                wgap_cnt--;
            end

            data_gnt_i = 1'b1;
            if (data_req_o && stall_left > 0 && acc_cnt == stall_beat) begin
                data_gnt_i = 1'b0;
                stall_left--;
            end
            r_acc = data_req_o & data_gnt_i;

            if (pend && !data_req_o) stab_err++;
            if (pend && data_req_o &&
                (data_addr_o !== p_addr || data_wdata_o !== p_wd ||
                 data_be_o !== p_be || data_we_o !== p_we)) stab_err++;
            if (data_req_o && !data_gnt_i) begin
                held++;
                if (!pend) begin
                    pend = 1'b1;
                    p_addr = data_addr_o;
                    p_wd = data_wdata_o;
                    p_be = data_be_o;
                    p_we = data_we_o;
                end
            end else begin
                pend = 1'b0;
            end

            if (r_rv) begin
                last_rv_cyc = cyc;
                if (!seen_rv) begin
                    seen_rv = 1'b1;
                    acc_before_rv = acc_cnt;
                end
            end
            if (r_acc && r_rv) both_cnt++;
            if (r_acc && !(r_rv && out_m > 0)) out_m++;
            else if (!r_acc && r_rv && out_m > 0) out_m--;
            if (out_m > max_out) max_out = out_m;

            if (r_acc) begin
                acc_addr.push_back(32'(data_addr_o));
                acc_be.push_back(32'(data_be_o));
                acc_cnt++;
                lv[lat] = 1'b1;
                if (data_we_o) begin
                    for (int b = 0; b < 4; b++)
                        if (data_be_o[b])
                            mem[data_addr_o[15:2]][8*b +: 8] = data_wdata_o[8*b +: 8];
                    ld[lat] = 32'hDEAD_BEEF;
                end else begin
                    ld[lat] = mem[data_addr_o[15:2]];
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clr();
        acc_addr.delete();
        acc_be.delete();
        rd_q.delete();
        acc_cnt = 0;
        wsent = 0;
        max_out = 0;
        both_cnt = 0;
        stab_err = 0;
        empty_err = 0;
        held = 0;
        seen_rv = 1'b0;
        acc_before_rv = -1;
    endtask

    task automatic start(input logic [15:0] a, input logic [7:0] l,
                         input logic w, input logic [3:0] b);
        cmd_addr_i = a;
        cmd_len_i = l;
        cmd_we_i = w;
        cmd_be_i = b;
        cmd_valid_i = 1'b1;
        tick();
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done_o && n < 300) begin
            tick();
            n++;
        end
        check(tag, 32'(done_o), 32'd1);
        done_cyc = cyc;
    endtask

    logic [31:0] exp_a [4];
    logic [31:0] exp_d [6];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_addr_i = '0;
        cmd_len_i = '0;
        cmd_we_i = 1'b0;
        cmd_be_i = '0;
        clr();
        for (int i = 0; i < 16384; i++) mem[i] = '0;
        for (int i = 0; i < 4; i++) mem[4+i] = 32'hA0 + 32'(i);
        tick();
        tick();
        check("rst_ready", 32'(cmd_ready_o), 1);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_req", 32'(data_req_o), 0);
        check("rst_done", 32'(done_o), 0);
        check("rst_err", 32'(err_o), 0);
        check("rst_rvalid", 32'(rdata_valid_o), 0);
        check("rst_wready", 32'(wdata_ready_o), 0);
        check("rst_addr", 32'(data_addr_o), 0);
        rst_n = 1'b1;
        tick();

        clr();
        lat = 1;
        start(16'h0010, 8'd3, 1'b0, 4'hF);
        check("t1_busy", 32'(busy_o), 1);
        check("t1_ready_busy", 32'(cmd_ready_o), 0);
        wait_done("t1_done");
        check("t1_done_lat", 32'(done_cyc), 32'(last_rv_cyc + 1));
        check("t1_ready_done", 32'(cmd_ready_o), 1);
        tick();
        check("t1_done_pulse", 32'(done_o), 0);
        exp_a = '{32'h10, 32'h14, 32'h18, 32'h1C};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_addr%0d", i), qget(acc_addr, i), exp_a[i]);
            check($sformatf("t1_rdata%0d", i), qget(rd_q, i), 32'hA0 + 32'(i));
        end
        check("t1_nrd", 32'(rd_q.size()), 4);

        clr();
        wgap = 2;
        wq.push_back(32'h1111_1111);
        wq.push_back(32'h2222_2222);
        start(16'h0103, 8'd1, 1'b1, 4'h3);
        wait_done("t2_done");
        tick();
        check("t2_addr0", qget(acc_addr, 0), 32'h100);
        check("t2_addr1", qget(acc_addr, 1), 32'h104);
        check("t2_be0", qget(acc_be, 0), 32'h3);
        check("t2_be1", qget(acc_be, 1), 32'h3);
        check("t2_nacc", 32'(acc_cnt), 2);
        check("t2_empty_req", 32'(empty_err), 0);
        check("t2_no_rdata", 32'(rd_q.size()), 0);
        check("t2_mem0", mem[16'h40], 32'h0000_1111);
        check("t2_mem1", mem[16'h41], 32'h0000_2222);
        wgap = 0;

        clr();
        lat = 4;
        for (int i = 0; i < 6; i++) begin
            mem[16'h80 + i] = 32'hC0 + 32'(i);
            exp_d[i] = 32'hC0 + 32'(i);
        end
        start(16'h0200, 8'd5, 1'b0, 4'hF);
        wait_done("t3_done");
        tick();
        check("t3_max_out", 32'(max_out), 2);
        check("t3_acc_before_rv", 32'(acc_before_rv), 2);
        check("t3_both", 32'(both_cnt != 0), 1);
        for (int i = 0; i < 6; i++)
            check($sformatf("t3_rdata%0d", i), qget(rd_q, i), exp_d[i]);
        lat = 1;

        clr();
        stall_beat = 1;
        stall_left = 5;
        wq.push_back(32'hAAAA_5555);
        wq.push_back(32'h1234_5678);
        wq.push_back(32'h0F0F_0F0F);
        start(16'h0300, 8'd2, 1'b1, 4'hF);
        wait_done("t4_done");
        tick();
        check("t4_held", 32'(held), 5);
        check("t4_stable", 32'(stab_err), 0);
        check("t4_empty_req", 32'(empty_err), 0);
        check("t4_addr0", qget(acc_addr, 0), 32'h300);
        check("t4_addr1", qget(acc_addr, 1), 32'h304);
        check("t4_addr2", qget(acc_addr, 2), 32'h308);
        check("t4_mem1", mem[16'hC1], 32'h1234_5678);
        check("t4_mem2", mem[16'hC2], 32'h0F0F_0F0F);
        stall_beat = -1;
        stall_left = 0;

        clr();
        spur = 1'b1;
        tick();
        tick();
        check("t5_err_set", 32'(err_o), 1);
        check("t5_spur_rd", 32'(rd_q.size()), 0);
        mem[16383] = 32'h5EED_0001;
        mem[0] = 32'h5EED_0002;
        start(16'hFFFC, 8'd1, 1'b0, 4'hF);
        wait_done("t5_done");
        tick();
        check("t5_addr0", qget(acc_addr, 0), 32'hFFFC);
        check("t5_addr1", qget(acc_addr, 1), 32'h0000);
        check("t5_rdata0", qget(rd_q, 0), 32'h5EED_0001);
        check("t5_rdata1", qget(rd_q, 1), 32'h5EED_0002);
        check("t5_err_sticky", 32'(err_o), 1);

        clr();
        stall_beat = 1;
        stall_left = 1000;
        start(16'h0010, 8'd3, 1'b0, 4'hF);
        repeat (4) tick();
        check("t6_req_pending", 32'(data_req_o), 1);
        rst_n = 1'b0;
        tick();
        check("t6_req", 32'(data_req_o), 0);
        check("t6_busy", 32'(busy_o), 0);
        check("t6_ready", 32'(cmd_ready_o), 1);
        check("t6_err", 32'(err_o), 0);
        check("t6_done", 32'(done_o), 0);
        stall_beat = -1;
        stall_left = 0;
        rst_n = 1'b1;
        tick();
        clr();
        start(16'h0014, 8'd1, 1'b0, 4'hF);
        wait_done("t6_rec_done");
        tick();
        check("t6_rec_rd0", qget(rd_q, 0), 32'hA1);
        check("t6_rec_rd1", qget(rd_q, 1), 32'hA2);
        check("t6_rec_err", 32'(err_o), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/obi_burst_master.md
Name: obi_burst_master

Overview:
- Bus initiator for the core-side req/gnt/rvalid memory protocol; drives the same port set a RAM responder serves.
- Accepts one burst command: start address, word count, read or write.
- Issues one word request per beat with incrementing addresses, tracks outstanding responses, streams read data out.
- Used by the verilator model as a program loader, memory checker and DMA-style test agent on the RAM data port.

Parameters:
- ADDR_WIDTH, 16: bus address width in bytes; 64KiB space.
- LEN_WIDTH, 8: width of cmd_len_i; burst length is cmd_len_i+1 words, 1..256.
- MAX_OUTSTANDING, 2: maximum granted requests awaiting rvalid; legal range 1..8.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_addr_i  in  ADDR_WIDTH  start byte address; bits[1:0] ignored
- cmd_len_i  in  LEN_WIDTH  words minus one
- cmd_we_i  in  1  1=write burst, 0=read burst
- cmd_be_i  in  4  byte enables applied to every beat
- wdata_valid_i  in  1  write-data stream valid
- wdata_ready_o  out  1  write-data stream ready
- wdata_i  in  32  write data beat
- rdata_valid_o  out  1  read beat valid, one cycle, no backpressure
- rdata_o  out  32  read beat data
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse, burst complete
- err_o  out  1  sticky: rvalid received with nothing outstanding
- data_req_o  out  1  bus request
- data_addr_o  out  ADDR_WIDTH  bus address, word aligned
- data_we_o  out  1  bus write enable
- data_be_o  out  4  bus byte enables
- data_wdata_o  out  32  bus write data
- data_gnt_i  in  1  grant
- data_rvalid_i  in  1  response valid
- data_rdata_i  in  32  response data

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE. All outputs 0 except cmd_ready_o=1. Outstanding count 0, write buffer empty, err_o cleared.
- Reset mid-burst: req dropped immediately, in-flight responses forgotten. Bench resets the responder together.
- States: IDLE, ISSUE, DRAIN.
- IDLE: cmd_ready_o=1. On cmd_valid_i, latch addr with [1:0]=00, remaining=len+1, we, be; go to ISSUE next cycle.
- Protocol: request accepted on a cycle with data_req_o&data_gnt_i. Once asserted, req, addr, we, be and wdata stay stable until that cycle. Exactly one rvalid per accepted request, read or write, in order, at least 1 cycle after grant. data_rdata_i is ignored for write bursts.
- Outstanding counter: +1 on accept, -1 on rvalid, unchanged when both occur. Never exceeds MAX_OUTSTANDING.
- Write buffer: one 32-bit entry. wdata_ready_o = (state==ISSUE) & we & buffer empty & beats still unbuffered. Loads on valid&ready; empties on bus accept.
- ISSUE:
  - data_req_o=1 when outstanding<MAX_OUTSTANDING (registered count) and either read, or write with buffer full.
  - The condition cannot become false while req waits, because the count only falls.
  - On each accept: address +4, modulo 2^ADDR_WIDTH (wraps to 0); remaining -1.
  - Accept of the last beat: go to DRAIN. No further req.
- DRAIN: on rvalid with outstanding==1 (and no accept), go to IDLE. done_o=1 in the first IDLE cycle, coincident with cmd_ready_o=1.
- Read data: rdata_valid_o<=data_rvalid_i & ~we & outstanding>0; rdata_o<=data_rdata_i. Latency 1 cycle after rvalid.
- rvalid with outstanding==0: ignored, no count change, err_o<=1 until reset.
- cmd_valid_i while busy is not accepted (cmd_ready_o=0).

Test Plan:
- Read burst, addr=0x0010, len=3, gnt tied 1, rvalid=gnt delayed 1 cycle, RAM preloaded 0xA0..0xA3 -> addresses 0x10,0x14,0x18,0x1C; rdata_o sequence A0..A3; done_o one cycle after 4th rvalid.
- Write burst, addr=0x0103, len=1, be=0x3, wdata stream 0x11111111/0x22222222 with a 2-cycle gap -> writes at 0x100/0x104 with be=0x3; req never asserted with empty buffer; no rdata_valid_o; done_o pulses.
- MAX_OUTSTANDING=2, rvalid delayed 4 cycles -> at most 2 accepts before first rvalid; counter never reaches 3; simultaneous gnt+rvalid keeps count 2.
- gnt held low 5 cycles during beat 2 -> req/addr/wdata stable all 5 cycles; address advances only after the grant cycle.
- addr=0xFFFC, len=1 -> second beat at 0x0000. Spurious rvalid in IDLE -> err_o=1 and stays 1; next burst still completes.
- rst_n low for 1 cycle mid-burst with req pending -> next cycle req=0, busy_o=0, cmd_ready_o=1, err_o=0.
